p12_scan_loader: RTL

P12_SCAN_LOADER -- requirements
Module: p12_scan_loader

---
 rtl/p12_scan_loader_if.sv | 30 +++
 rtl/p12_scan_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/p12_scan_loader_if.sv
// Handshake and scan-chain bundle for p12_scan_loader.
// master: drives start, in_data, in_valid, scan_in.
// slave:  drives in_ready, scan_en, scan_out, rb_data,
//         rb_valid, busy, done, err.
interface p12_scan_loader_if;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       scan_en;
    logic       scan_out;
    logic       scan_in;
    logic [7:0] rb_data;
    logic       rb_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, in_data, in_valid, scan_in,
        input  in_ready, scan_en, scan_out,
        input  rb_data, rb_valid, busy, done, err
    );

    modport slave (
        input  start, in_data, in_valid, scan_in,
        output in_ready, scan_en, scan_out,
        output rb_data, rb_valid, busy, done, err
    );
endinterface

// File: rtl/p12_scan_loader.sv
// Byte-fed scan chain loader with serial readback.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   start/in_data/in_valid/in_ready byte feed,
//   scan_en/scan_out/scan_in chain, rb_data/rb_valid
//   readback, busy/done/err status.
module p12_scan_loader #(
    parameter int CHAIN_LEN = 64
) (
    input logic            clk,
    input logic            rst,
    p12_scan_loader_if.slave bus
);

    localparam int CW = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHIFT,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0] r_cnt;
    logic [7:0]    r_sr;
    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic [7:0]    r_rb;
    logic          r_rb_valid;
    logic          r_err;

    logic w_bit7;
    logic w_last;
    logic w_start_ok;
    logic w_ld_in;
    logic w_ld_hold;
    logic w_hold_ld;
    logic w_to_err;
    logic w_in_ready;
    logic w_scan_en;
    logic w_busy;
    logic w_done;

    assign w_bit7 = (r_cnt[2:0] == 3'd7);
    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_ld_in    = 1'b0;
        w_ld_hold  = 1'b0;
        w_hold_ld  = 1'b0;
        w_to_err   = 1'b0;
        w_in_ready = 1'b0;
        w_scan_en  = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next     = S_FILL;
                    w_start_ok = 1'b1;
                end
            end
            S_FILL: begin
                w_busy     = 1'b1;
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_ld_in = 1'b1;
                    w_next  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy     = 1'b1;
                w_scan_en  = 1'b1;
                w_in_ready = !r_hold_full;
                if (w_last) begin
                    w_next = S_DONE;
                end else if (w_bit7) begin
                    // Byte boundary: the next byte must come
                    // from holding or straight off the bus.
                    if (r_hold_full) begin
                        w_ld_hold = 1'b1;
                    end else if (bus.in_valid) begin
                        w_ld_in = 1'b1;
                    end else begin
                        w_next   = S_ERR;
                        w_to_err = 1'b1;
                    end
                end else begin
                    w_hold_ld = bus.in_valid && !r_hold_full;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                if (bus.start) begin
                    w_next     = S_FILL;
                    w_start_ok = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_sr        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rb        <= '0;
            r_rb_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_start_ok) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_to_err) begin
                r_err <= 1'b1;
            end
            if (w_ld_in) begin
                r_sr <= bus.in_data;
            end else if (w_ld_hold) begin
                r_sr <= r_hold;
            end else if (w_scan_en) begin
                r_sr <= {1'b0, r_sr[7:1]};
            end
            if (w_scan_en) begin
                r_cnt      <= r_cnt + CW'(1);
                // Returned bits enter at the top so the
                // first one ends up in bit 0.
                r_rb       <= {bus.scan_in, r_rb[7:1]};
                r_rb_valid <= w_bit7;
            end
            if (w_hold_ld) begin
                r_hold      <= bus.in_data;
                r_hold_full <= 1'b1;
            end else if (w_ld_hold) begin
                r_hold_full <= 1'b0;
            end else if (w_done) begin
                r_hold      <= '0;
                r_hold_full <= 1'b0;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.scan_en  = w_scan_en;
    assign bus.scan_out = w_scan_en & r_sr[0];
    assign bus.rb_data  = r_rb;
    assign bus.rb_valid = r_rb_valid;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.err      = r_err;

endmodule
